// File: rtl/piso_unload_fifo.sv
// Parallel-in, serial-out word FIFO: loads a DEPTH-word vector in one handshake,
// then emits it one word per output handshake, least significant word first.
module piso_unload_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [WIDTH*DEPTH-1:0]       load_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             outp,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH*DEPTH-1:0] r_sr;
  logic [CW-1:0]          r_cnt;

  logic w_empty;
  logic w_last;
  logic w_load_ready;
  logic w_out_valid;
  logic w_load_fire;
  logic w_out_fire;

  always_comb begin
    w_empty      = (r_cnt == '0);
    w_last       = (r_cnt == CW'(1));
    // A new vector may land in the same cycle the final word of the old one leaves.
    w_load_ready = en && (w_empty || (w_last && out_ready));
    w_out_valid  = en && !w_empty;
    w_load_fire  = load_valid && w_load_ready;
    w_out_fire   = w_out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_load_fire) begin
      r_sr  <= load_data;
      r_cnt <= CW'(DEPTH);
    end else if (w_out_fire) begin
      r_sr  <= {{WIDTH{1'b0}}, r_sr[WIDTH*DEPTH-1:WIDTH]};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    load_ready = w_load_ready;
    out_valid  = w_out_valid;
    outp       = r_sr[WIDTH-1:0];
    out_last   = w_last;
    count      = r_cnt;
  end

endmodule
